// File: rtl/rbm_gibbs_scheduler.sv
// Gibbs-sampling run scheduler for an RBM classifier: sequences hidden and
// classifier group passes per iteration and accumulates per-output votes.
module rbm_gibbs_scheduler #(
    parameter int unsigned            OUTPUT_DIM       = 10,
    parameter int unsigned            W_BITLENGTH      = 12,
    parameter logic [W_BITLENGTH-1:0] INF              = 12'b0111_1111_1111,
    parameter int unsigned            HIDDEN_GROUP_NUM = 1,
    parameter int unsigned            CL_GROUP_NUM     = 1,
    parameter int unsigned            ITERATION_NUM    = 100,
    localparam int unsigned HG_W = (HIDDEN_GROUP_NUM > 1) ? $clog2(HIDDEN_GROUP_NUM) : 1,
    localparam int unsigned CG_W = (CL_GROUP_NUM > 1) ? $clog2(CL_GROUP_NUM) : 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              data_valid,
    output logic                              h_start,
    output logic [HG_W-1:0]                   h_group,
    input  logic                              h_done,
    output logic                              cl_start,
    output logic [CG_W-1:0]                   cl_group,
    input  logic                              cl_done,
    input  logic [OUTPUT_DIM-1:0]             cl_sample,
    output logic [15:0]                       iter_count,
    output logic                              busy,
    output logic [OUTPUT_DIM*W_BITLENGTH-1:0] VotePort,
    output logic                              finish
);

    typedef enum logic [2:0] {
        IDLE,
        H_ISSUE,
        H_WAIT,
        CL_ISSUE,
        CL_WAIT,
        ACCUM,
        DONE
    } state_e;

    localparam logic [HG_W-1:0] H_LAST    = HG_W'(HIDDEN_GROUP_NUM - 1);
    localparam logic [CG_W-1:0] CL_LAST   = CG_W'(CL_GROUP_NUM - 1);
    localparam logic [15:0]     ITER_LAST = 16'(ITERATION_NUM - 1);

    state_e state_q, state_d;

    logic [HG_W-1:0]                        h_group_q, h_group_d;
    logic [CG_W-1:0]                        cl_group_q, cl_group_d;
    logic [15:0]                            iter_q, iter_d;
    logic [OUTPUT_DIM-1:0]                  sample_q, sample_d;
    logic [OUTPUT_DIM-1:0][W_BITLENGTH-1:0] votes_q, votes_d;

    logic h_last, cl_last;

    assign h_last  = (h_group_q == H_LAST);
    assign cl_last = (cl_group_q == CL_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (data_valid) state_d = H_ISSUE;
            H_ISSUE:  state_d = H_WAIT;
            H_WAIT:   if (h_done) state_d = h_last ? CL_ISSUE : H_ISSUE;
            CL_ISSUE: state_d = CL_WAIT;
            CL_WAIT:  if (cl_done) state_d = cl_last ? ACCUM : CL_ISSUE;
            ACCUM:    state_d = (iter_q == ITER_LAST) ? DONE : H_ISSUE;
            DONE:     if (!data_valid) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        h_start  = 1'b0;
        cl_start = 1'b0;
        busy     = 1'b1;
        finish   = 1'b0;
        case (state_q)
            IDLE:     busy = 1'b0;
            H_ISSUE:  h_start = 1'b1;
            CL_ISSUE: cl_start = 1'b1;
            DONE: begin
                busy   = 1'b0;
                finish = 1'b1;
            end
            default: ;
        endcase
    end

    // Done inputs only take effect in the matching WAIT state; a done seen
    // during the ISSUE cycle is ignored.
    always_comb begin
        h_group_d  = h_group_q;
        cl_group_d = cl_group_q;
        iter_d     = iter_q;
        sample_d   = sample_q;
        votes_d    = votes_q;
        case (state_q)
            IDLE: begin
                if (data_valid) begin
                    h_group_d  = '0;
                    cl_group_d = '0;
                    iter_d     = '0;
                    votes_d    = '0;
                end
            end
            H_WAIT: begin
                if (h_done) begin
                    h_group_d = h_last ? '0 : h_group_q + 1'b1;
                end
            end
            CL_WAIT: begin
                if (cl_done) begin
                    cl_group_d = cl_last ? '0 : cl_group_q + 1'b1;
                    if (cl_last) begin
                        sample_d = cl_sample;
                    end
                end
            end
            ACCUM: begin
                iter_d = iter_q + 16'd1;
                for (int unsigned i = 0; i < OUTPUT_DIM; i++) begin
                    if (sample_q[i] && (votes_q[i] < INF)) begin
                        votes_d[i] = votes_q[i] + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            h_group_q  <= '0;
            cl_group_q <= '0;
            iter_q     <= '0;
            sample_q   <= '0;
            votes_q    <= '0;
        end else begin
            h_group_q  <= h_group_d;
            cl_group_q <= cl_group_d;
            iter_q     <= iter_d;
            sample_q   <= sample_d;
            votes_q    <= votes_d;
        end
    end

    assign h_group    = h_group_q;
    assign cl_group   = cl_group_q;
    assign iter_count = iter_q;
    assign VotePort   = votes_q;

endmodule

// File: tb/tb_rbm_gibbs_scheduler.sv
// Bench for rbm_gibbs_scheduler: three parameterisations driven by a scripted
// responder whose per-cycle expectations come from a loop-level run model.
module tb_rbm_gibbs_scheduler;

    localparam int ND = 3;
    localparam int OD = 10;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          rst_n;
    logic          dv  [ND];
    logic          hd  [ND];
    logic          cd  [ND];
    logic [OD-1:0] smp [ND];
    logic          hs  [ND];
    logic          cs  [ND];
    logic          bsy [ND];
    logic          fin [ND];
    logic [15:0]   itc [ND];

    logic [0:0]   hg0, cg0, cg1, hg2, cg2;
    logic [1:0]   hg1;
    logic [119:0] vp0, vp1;
    logic [39:0]  vp2;

    int o_hg [ND];
    int o_cg [ND];
    int o_vote [ND][OD];

    int HGN  [ND] = '{1, 3, 1};
    int CGN  [ND] = '{1, 2, 1};
    int ITN  [ND] = '{100, 2, 20};
    int INFV [ND] = '{2047, 2047, 7};

    rbm_gibbs_scheduler u_dut0 (
        .clock(clock), .reset(rst_n), .data_valid(dv[0]),
        .h_start(hs[0]), .h_group(hg0), .h_done(hd[0]),
        .cl_start(cs[0]), .cl_group(cg0), .cl_done(cd[0]), .cl_sample(smp[0]),
        .iter_count(itc[0]), .busy(bsy[0]), .VotePort(vp0), .finish(fin[0])
    );

    rbm_gibbs_scheduler #(
        .HIDDEN_GROUP_NUM(3), .CL_GROUP_NUM(2), .ITERATION_NUM(2)
    ) u_dut1 (
        .clock(clock), .reset(rst_n), .data_valid(dv[1]),
        .h_start(hs[1]), .h_group(hg1), .h_done(hd[1]),
        .cl_start(cs[1]), .cl_group(cg1), .cl_done(cd[1]), .cl_sample(smp[1]),
        .iter_count(itc[1]), .busy(bsy[1]), .VotePort(vp1), .finish(fin[1])
    );

    rbm_gibbs_scheduler #(
        .W_BITLENGTH(4), .INF(4'd7), .ITERATION_NUM(20)
    ) u_dut2 (
        .clock(clock), .reset(rst_n), .data_valid(dv[2]),
        .h_start(hs[2]), .h_group(hg2), .h_done(hd[2]),
        .cl_start(cs[2]), .cl_group(cg2), .cl_done(cd[2]), .cl_sample(smp[2]),
        .iter_count(itc[2]), .busy(bsy[2]), .VotePort(vp2), .finish(fin[2])
    );

    always_comb begin
        o_hg[0] = int'(hg0);
        o_hg[1] = int'(hg1);
        o_hg[2] = int'(hg2);
        o_cg[0] = int'(cg0);
        o_cg[1] = int'(cg1);
        o_cg[2] = int'(cg2);
        for (int i = 0; i < OD; i++) begin
            o_vote[0][i] = int'(vp0[i*12 +: 12]);
            o_vote[1][i] = int'(vp1[i*12 +: 12]);
            o_vote[2][i] = int'(vp2[i*4 +: 4]);
        end
    end

    int vectors = 0;
    int miscompares = 0;

    int sel = 0;
    bit chk_en = 1'b0;
    bit e_busy, e_fin, e_hs, e_cs;
    int e_hg, e_cg, e_iter;
    int e_vote [OD];

    int edge_no = 0;
    int t0_edge, fin_edge;
    bit fin_seen;
    int h_pulses, cl_pulses, h_seq, cl_seq;

    task automatic check(input string nm, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (dut %0d, t=%0t)", nm, act, req, sel, $time);
        end
    endtask

    always @(posedge clock) edge_no++;

    always @(negedge clock) begin
        if (chk_en) begin
            check("busy", int'(bsy[sel]), int'(e_busy));
            check("finish", int'(fin[sel]), int'(e_fin));
            check("h_start", int'(hs[sel]), int'(e_hs));
            check("cl_start", int'(cs[sel]), int'(e_cs));
            check("h_group", o_hg[sel], e_hg);
            check("cl_group", o_cg[sel], e_cg);
            check("iter_count", int'(itc[sel]), e_iter);
            for (int i = 0; i < OD; i++)
                check($sformatf("vote[%0d]", i), o_vote[sel][i], e_vote[i]);
            if (hs[sel]) begin
                h_pulses++;
                h_seq = h_seq * 4 + o_hg[sel];
            end
            if (cs[sel]) begin
                cl_pulses++;
                cl_seq = cl_seq * 4 + o_cg[sel];
            end
            if (fin[sel] && !fin_seen) begin
                fin_seen = 1'b1;
                fin_edge = edge_no;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_exp(input bit b, input bit f, input bit h, input bit c,
                           input int hg, input int cg);
        e_busy = b; e_fin = f; e_hs = h; e_cs = c; e_hg = hg; e_cg = cg;
    endtask

    task automatic clear_model();
        e_iter = 0;
        for (int i = 0; i < OD; i++) e_vote[i] = 0;
    endtask

    // Random spurious dones where they must be ignored, plus sample garbage.
    task automatic noise(input int s, input bit noisy, input bit h_ok, input bit c_ok);
        hd[s] = (noisy && h_ok) ? 1'($urandom_range(0, 1)) : 1'b0;
        cd[s] = (noisy && c_ok) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noisy) smp[s] = OD'($urandom);
    endtask

    task automatic select_dut(input int s);
        sel = s;
        clear_model();
        set_exp(0, 0, 0, 0, 0, 0);
    endtask

    // Entered and left at a slot where the selected DUT sits in IDLE.
    task automatic run_image(input int s, input bit noisy, input int fsamp, input int abort_it);
        int samp, d, hold;
        set_exp(0, 0, 0, 0, 0, 0);
        noise(s, noisy, 1, 1);
        dv[s] = 1'b1;
        tick();
        t0_edge = edge_no;
        fin_seen = 1'b0;
        h_pulses = 0; cl_pulses = 0; h_seq = 0; cl_seq = 0;
        clear_model();
        for (int it = 0; it < ITN[s]; it++) begin
            if (it == abort_it) begin
                rst_n = 1'b0;
                dv[s] = 1'b0; hd[s] = 1'b0; cd[s] = 1'b0;
                clear_model();
                set_exp(0, 0, 0, 0, 0, 0);
                repeat (3) tick();
                rst_n = 1'b1;
                tick();
                return;
            end
            samp = (fsamp >= 0) ? fsamp : int'($urandom_range(0, 1023));
            for (int g = 0; g < HGN[s]; g++) begin
                set_exp(1, 0, 1, 0, g, 0);
                noise(s, noisy, 1, 1);
                if (noisy) dv[s] = 1'($urandom_range(0, 1));
                tick();
                set_exp(1, 0, 0, 0, g, 0);
                d = noisy ? int'($urandom_range(0, 7)) : 0;
                repeat (d) begin noise(s, noisy, 0, 1); tick(); end
                noise(s, noisy, 0, 1);
                hd[s] = 1'b1;
                tick();
            end
            for (int g = 0; g < CGN[s]; g++) begin
                set_exp(1, 0, 0, 1, 0, g);
                noise(s, noisy, 1, 1);
                if (noisy) dv[s] = 1'($urandom_range(0, 1));
                tick();
                set_exp(1, 0, 0, 0, 0, g);
                d = noisy ? int'($urandom_range(0, 7)) : 0;
                repeat (d) begin noise(s, noisy, 1, 0); tick(); end
                noise(s, noisy, 1, 0);
                cd[s] = 1'b1;
                if (g == CGN[s] - 1) smp[s] = OD'(samp);
                tick();
            end
            set_exp(1, 0, 0, 0, 0, 0);
            noise(s, noisy, 1, 1);
            tick();
            for (int i = 0; i < OD; i++)
                if (((samp >> i) & 1) == 1 && e_vote[i] < INFV[s]) e_vote[i]++;
            e_iter++;
        end
        set_exp(0, 1, 0, 0, 0, 0);
        hold = int'($urandom_range(2, 5));
        repeat (hold) begin noise(s, noisy, 1, 1); dv[s] = 1'b1; tick(); end
        noise(s, noisy, 1, 1);
        dv[s] = 1'b0;
        tick();
        set_exp(0, 0, 0, 0, 0, 0);
        repeat (2) begin noise(s, noisy, 1, 1); tick(); end
        hd[s] = 1'b0; cd[s] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int s = 0; s < ND; s++) begin
            dv[s] = 1'b0; hd[s] = 1'b0; cd[s] = 1'b0; smp[s] = '0;
        end
        select_dut(0);
        tick();
        chk_en = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        run_image(0, 1'b0, 4, -1);
        check("lit_finish_edge", fin_edge - t0_edge, 500);
        check("lit_vote2", o_vote[0][2], 100);
        check("lit_vote0", o_vote[0][0], 0);
        check("lit_vote9", o_vote[0][9], 0);
        check("lit_iter", int'(itc[0]), 100);

        run_image(0, 1'b1, -1, -1);
        run_image(0, 1'b1, -1, 37);
        check("lit_abort_iter", int'(itc[0]), 0);
        check("lit_abort_vote2", o_vote[0][2], 0);
        run_image(0, 1'b1, -1, -1);

        select_dut(1);
        run_image(1, 1'b0, -1, -1);
        check("lit_h_pulses", h_pulses, 6);
        check("lit_cl_pulses", cl_pulses, 4);
        check("lit_h_seq", h_seq, 390);
        check("lit_cl_seq", cl_seq, 17);
        run_image(1, 1'b1, -1, -1);

        select_dut(2);
        run_image(2, 1'b0, 1023, -1);
        for (int i = 0; i < OD; i++)
            check($sformatf("lit_sat_vote[%0d]", i), o_vote[2][i], 7);
        check("lit_sat_iter", int'(itc[2]), 20);
        run_image(2, 1'b1, -1, -1);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
